// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/occupancy sequencer for a width-converting scratch FIFO memory.
// Define FIFO_CTRL_ERR_EN to build sticky overflow/underflow flags; otherwise they are tied to 0.
module fifo_ctrl #(
  parameter int R_DATA_WIDTH = 64,
  parameter int W_DATA_WIDTH = 16,
  parameter int MEM_WIDTH    = 16,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic                  pop_ready,
  output logic                  pop_valid,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int W_WORDS = W_DATA_WIDTH / MEM_WIDTH;
  localparam int R_WORDS = R_DATA_WIDTH / MEM_WIDTH;
  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] W_CNT = CW'(W_WORDS);
  localparam logic [CW-1:0] R_CNT = CW'(R_WORDS);
  localparam logic [CW-1:0] W_LIM = CW'(DEPTH - W_WORDS);
  localparam logic [CW-1:0] D_CNT = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] W_STEP = ADDR_WIDTH'(W_WORDS);
  localparam logic [ADDR_WIDTH-1:0] R_STEP = ADDR_WIDTH'(R_WORDS);
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_push, w_pop;
  assign push_ready  = r_count <= W_LIM;
  assign pop_valid   = r_count >= R_CNT;
  assign full        = r_count == D_CNT;
  assign empty       = r_count == '0;
  // rst_n gating keeps the memory write strobe quiet while reset is held
  assign w_push      = rst_n && !clear && push_valid && push_ready;
  assign w_pop       = !clear && pop_valid && pop_ready;
  assign mem_wr_en   = w_push;
  assign mem_rd_en   = pop_valid;
  assign mem_wr_addr = r_wr_ptr;
  assign mem_rd_addr = r_rd_ptr;
  assign count       = r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + W_STEP;
      if (w_pop) r_rd_ptr <= r_rd_ptr + R_STEP;
      r_count <= r_count + (w_push ? W_CNT : '0) - (w_pop ? R_CNT : '0);
    end
  end
`ifdef FIFO_CTRL_ERR_EN
  logic r_overflow, r_underflow;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push_valid && !push_ready) r_overflow <= 1'b1;
      if (pop_ready && !pop_valid) r_underflow <= 1'b1;
    end
  end
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed self-checking bench for fifo_ctrl with a 16-bit behavioural memory beside it.
module tb_fifo_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, push_valid = 1'b0, pop_ready = 1'b0;
  logic        push_ready, pop_valid, mem_wr_en, mem_rd_en, full, empty, overflow, underflow;
  logic [7:0]  mem_wr_addr, mem_rd_addr;
  logic [8:0]  count;
  logic [15:0] wdata = 16'd0;
  logic [15:0] mem [256];
  int vectors = 0, miscompares = 0;
`ifdef FIFO_CTRL_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .push_valid(push_valid), .push_ready(push_ready),
    .pop_ready(pop_ready), .pop_valid(pop_valid),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (mem_wr_en) mem[mem_wr_addr] <= wdata;

  function automatic logic [63:0] rd_data();
    logic [7:0] a;
    a = mem_rd_addr;
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int n);
    push_valid = 1'b1;
    repeat (n) begin
      tick();
      wdata++;
    end
    push_valid = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_push_ready", push_ready, 1);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wdata = 16'd1;
    push(3);
    chk("lat_count3", count, 3);
    chk("lat_pop_valid0", pop_valid, 0);
    chk("lat_wr_addr3", mem_wr_addr, 3);
    push_valid = 1'b1;
    #1;
    chk("lat_wr_en", mem_wr_en, 1);
    tick();
    wdata++;
    push_valid = 1'b0;
    chk("lat_pop_valid1", pop_valid, 1);
    chk("lat_rd_en", mem_rd_en, 1);
    chk("lat_rd_addr", mem_rd_addr, 0);
    chk("lat_count4", count, 4);
    chk("lat_rd_data", rd_data(), 64'h0004_0003_0002_0001);
    push_valid = 1'b1;
    pop_ready  = 1'b1;
    #1;
    chk("sim_wr_en", mem_wr_en, 1);
    tick();
    wdata++;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    chk("sim_count", count, 1);
    chk("sim_wr_addr", mem_wr_addr, 5);
    chk("sim_rd_addr", mem_rd_addr, 4);
    chk("sim_pop_valid", pop_valid, 0);
    push(36);
    chk("mid_count37", count, 37);
    push_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_count", count, 0);
    chk("mid_push_ready", push_ready, 1);
    chk("mid_pop_valid", pop_valid, 0);
    chk("mid_wr_en", mem_wr_en, 0);
    chk("mid_wr_addr", mem_wr_addr, 0);
    chk("mid_rd_addr", mem_rd_addr, 0);
    chk("mid_empty", empty, 1);
    push_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mid_count_after", count, 0);
    wdata = 16'd0;
    push(256);
    chk("full_count", count, 256);
    chk("full_flag", full, 1);
    chk("full_push_ready", push_ready, 0);
    chk("full_empty", empty, 0);
    chk("full_wr_addr", mem_wr_addr, 0);
    push_valid = 1'b1;
    #1;
    chk("over_wr_en", mem_wr_en, 0);
    tick();
    push_valid = 1'b0;
    chk("over_count", count, 256);
    chk("over_wr_addr", mem_wr_addr, 0);
    chk("over_flag", overflow, ERR);
    pop_ready = 1'b1;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (i == 0) begin
        chk("pop1_push_ready", push_ready, 1);
        chk("pop1_count", count, 252);
      end
    end
    pop_ready = 1'b0;
    chk("wrap_rd_addr252", mem_rd_addr, 252);
    chk("wrap_count4", count, 4);
    push(4);
    chk("wrap_wr_addr", mem_wr_addr, 4);
    chk("wrap_count8", count, 8);
    chk("wrap_rd_data", rd_data(), 64'h00ff_00fe_00fd_00fc);
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    chk("wrap_rd_addr0", mem_rd_addr, 0);
    chk("wrap_count_pop", count, 4);
    chk("wrap_rd_data0", rd_data(), 64'h0103_0102_0101_0100);
    clear = 1'b1;
    push_valid = 1'b1;
    #1;
    chk("clr_wr_en", mem_wr_en, 0);
    tick();
    clear = 1'b0;
    push_valid = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_empty", empty, 1);
    chk("clr_wr_addr", mem_wr_addr, 0);
    chk("clr_rd_addr", mem_rd_addr, 0);
    chk("clr_overflow", overflow, 0);
    pop_ready = 1'b1;
    #1;
    chk("und_rd_en", mem_rd_en, 0);
    tick();
    pop_ready = 1'b0;
    chk("und_flag", underflow, ERR);
    chk("und_count", count, 0);
    chk("und_rd_addr", mem_rd_addr, 0);
    tick();
    chk("und_held", underflow, ERR);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("und_clr", underflow, 0);
    chk("und_clr_count", count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flow-control sequencer for the PE's width-converting scratch FIFO memory: it accepts write-side pushes and read-side pops, generates the memory's `wr_en`/`wr_addr`/`rd_en`/`rd_addr`, and tracks occupancy in memory entries. It sits beside the FIFO memory inside each PE buffer (ifmap/filter/psum), so the memory itself stays a pure storage array. Write and read granules may differ (e.g. 16-bit in, 64-bit out); the controller advances each pointer by its granule size in entries and exposes a ready/valid handshake on both sides.

## Interface
- `R_DATA_WIDTH`, 64, read granule width in bits; must be a multiple of `MEM_WIDTH`.
- `W_DATA_WIDTH`, 16, write granule width in bits; must be a multiple of `MEM_WIDTH`.
- `MEM_WIDTH`, 16, memory entry width.
- `ADDR_WIDTH`, 8, entry address width; depth is 2**ADDR_WIDTH (256).
- Derived: `W_WORDS` = W_DATA_WIDTH/MEM_WIDTH (1); `R_WORDS` = R_DATA_WIDTH/MEM_WIDTH (4). Both must be powers of two and ≤ depth.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush.
- `push_valid` in 1: writer offers one W granule.
- `push_ready` out 1: free entries ≥ W_WORDS.
- `pop_ready` in 1: reader consumes one R granule.
- `pop_valid` out 1: count ≥ R_WORDS.
- `mem_wr_en` out 1: to memory `wr_en`.
- `mem_wr_addr` out ADDR_WIDTH: to memory `wr_addr`; equals write pointer.
- `mem_rd_en` out 1: to memory `rd_en`; equals `pop_valid`.
- `mem_rd_addr` out ADDR_WIDTH: to memory `rd_addr`; equals read pointer.
- `count` out ADDR_WIDTH+1: occupied entries, 0..depth.
- `full` out 1: count == depth.
- `empty` out 1: count == 0.
- `overflow`, `underflow` out 1: sticky error flags (see Configuration).

## Operation
- State: `wr_ptr`, `rd_ptr` (ADDR_WIDTH, wrap modulo depth), `count` (ADDR_WIDTH+1).
- push accepted = `push_valid && push_ready`; `mem_wr_en` = push accepted (combinational, so the memory's negedge write lands in the same cycle).
- pop accepted = `pop_valid && pop_ready`.
- On a rising edge: push accepted → wr_ptr += W_WORDS; pop accepted → rd_ptr += R_WORDS; count += (push ? W_WORDS : 0) − (pop ? R_WORDS : 0).
- Both accepted in the same cycle: both pointers advance; count is the net sum. `push_ready` and `pop_valid` are judged on pre-edge count only; no pass-through of same-cycle push data to pop.
- Wrap-around: pointers roll over naturally; a read granule may straddle the top of memory (rd_ptr = 252 → entries 252..255, next granule at 0). Memory address arithmetic wraps at ADDR_WIDTH bits.
- `clear` = 1: pointers and count zeroed on the edge, error flags cleared; overrides push/pop in that cycle (`mem_wr_en` forced 0).
- No FSM beyond the occupancy counter; `full`/`empty`/`push_ready`/`pop_valid` are combinational decodes of `count`.

## Timing
- Reset (rst_n = 0, async, any time including mid-transfer): wr_ptr = rd_ptr = count = 0; outputs: `push_ready` 1, `pop_valid` 0, `mem_wr_en` 0, `mem_rd_en` 0, addresses 0, `count` 0, `full` 0, `empty` 1, `overflow` 0, `underflow` 0.
- Push-to-pop latency: the push accepted at edge N that brings count to ≥ R_WORDS makes `pop_valid` 1 in the cycle after edge N; `rd_data` is valid FWFT in that same cycle.
- Pop: data is consumed at the edge where `pop_ready` is 1; the next granule address is presented the cycle after.
- Full: `push_ready` drops the cycle after the filling edge and rises the cycle after a pop frees ≥ W_WORDS entries.

## Configuration
- `FIFO_CTRL_ERR_EN` defined: `overflow` sets on any cycle with `push_valid && !push_ready`; `underflow` sets on `pop_ready && !pop_valid`; both are sticky until `clear` or reset.
- Not defined: `overflow` and `underflow` tied to 0; no flag registers are built. Handshake behaviour is identical either way.

## Test plan
- Reset: assert rst_n = 0 mid-stream with count = 37 → all outputs at reset values immediately, count 0 after release.
- Latency: push 3 words (0x0001..0x0003) → `pop_valid` 0; 4th push → `pop_valid` 1 next cycle, `mem_rd_addr` 0, rd_data = 0x0004_0003_0002_0001.
- Full: 256 pushes → count 256, `full` 1, `push_ready` 0; extra push ignored, wr_ptr stays 0.
- Wrap: fill 256, pop 63 granules, push 4 (wr_ptr 0→4) → rd_ptr 252, next pop returns entries 252..255, then rd_ptr 0.
- Simultaneous: count = 4, push and pop in one cycle → count 1, wr_ptr +1, rd_ptr +4.
- With `FIFO_CTRL_ERR_EN`: `pop_ready` at count 0 → `underflow` 1 and held; `clear` → 0 next cycle, count 0.
